way_sel_ctrl: RTL and testbench

Sequencing controller for the 4-way set-associative data path. It accepts a lookup (set index plus per-way tag-hit vector) and drives the one-hot way select consumed by the 4:1 line-data mux. It keeps per-set tree pseudo-LRU replacement state. On a miss it requests a fill into the chosen victim way and holds the select until the response is taken.

---
 rtl/way_sel_ctrl_if.sv | 37 +++
 rtl/way_sel_ctrl.sv | 164 ++++++++++++++++
 tb/tb_way_sel_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/way_sel_ctrl_if.sv
// Lookup / response / fill bundle between a 4-way cache data path and way_sel_ctrl.
// valid_vec exists only when WAY_SEL_INVALID_FIRST_EN is defined.
interface way_sel_ctrl_if #(
  parameter int SET_IDX_W = 6
);
  logic                 req_valid;
  logic                 req_ready;
  logic [SET_IDX_W-1:0] req_set;
  logic [3:0]           hit_vec;
`ifdef WAY_SEL_INVALID_FIRST_EN
  logic [3:0]           valid_vec;
`endif
  logic [3:0]           way_sel;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_hit;
  logic                 fill_req;
  logic [3:0]           victim_way;
  logic                 fill_done;
  logic                 err_multihit;

  modport master (
`ifdef WAY_SEL_INVALID_FIRST_EN
    output valid_vec,
`endif
    output req_valid, req_set, hit_vec, resp_ready, fill_done,
    input  req_ready, way_sel, resp_valid, resp_hit, fill_req, victim_way, err_multihit
  );

  modport slave (
`ifdef WAY_SEL_INVALID_FIRST_EN
    input  valid_vec,
`endif
    input  req_valid, req_set, hit_vec, resp_ready, fill_done,
    output req_ready, way_sel, resp_valid, resp_hit, fill_req, victim_way, err_multihit
  );
endinterface

// File: rtl/way_sel_ctrl.sv
// Way-select sequencer for a 4-way set-associative data path with per-set tree PLRU.
// Optional: define WAY_SEL_INVALID_FIRST_EN to prefer invalid ways as miss victims.
module way_sel_ctrl #(
  parameter int NUM_SETS  = 64,
  parameter int SET_IDX_W = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  way_sel_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, FILL, RESP} state_t;

  state_t               state, state_next;
  logic [SET_IDX_W-1:0] set_q;
  logic [3:0]           hit_q;
`ifdef WAY_SEL_INVALID_FIRST_EN
  logic [3:0]           valid_q;
`endif
  logic [2:0]           plru [NUM_SETS];

  logic [3:0] way_sel_q, way_sel_d;
  logic [3:0] victim_q, victim_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_hit_q, resp_hit_d;
  logic       fill_req_q, fill_req_d;
  logic       err_q, err_d;

  logic       capture;
  logic       plru_we;
  logic [3:0] plru_way;
  logic [2:0] plru_cur;
  logic [3:0] hit_low;
  logic       multi_hit;
  logic [3:0] victim_pick;

  // b0 picks the pair, b1/b2 pick within the left/right pair.
  function automatic logic [3:0] plru_victim(input logic [2:0] b);
    if (!b[0]) return b[1] ? 4'b0010 : 4'b0001;
    return b[2] ? 4'b1000 : 4'b0100;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [3:0] way);
    logic [2:0] r;
    r = b;
    case (way)
      4'b0001: begin r[0] = 1'b1; r[1] = 1'b1; end
      4'b0010: begin r[0] = 1'b1; r[1] = 1'b0; end
      4'b0100: begin r[0] = 1'b0; r[2] = 1'b1; end
      4'b1000: begin r[0] = 1'b0; r[2] = 1'b0; end
      default: r = b;
    endcase
    return r;
  endfunction

  assign plru_cur  = plru[set_q];
  assign hit_low   = hit_q & (~hit_q + 4'd1);
  assign multi_hit = |(hit_q & (hit_q - 4'd1));

`ifdef WAY_SEL_INVALID_FIRST_EN
  // Lowest-index invalid way wins; PLRU only breaks the tie when the set is full.
  always_comb begin
    if (&valid_q) victim_pick = plru_victim(plru_cur);
    else          victim_pick = ~valid_q & (valid_q + 4'd1);
  end
`else
  assign victim_pick = plru_victim(plru_cur);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      set_q        <= '0;
      hit_q        <= '0;
`ifdef WAY_SEL_INVALID_FIRST_EN
      valid_q      <= '0;
`endif
      way_sel_q    <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      fill_req_q   <= 1'b0;
      err_q        <= 1'b0;
      // NOTE: the PLRU array must come out of reset cleared, so it lives in
      // flops with the async reset rather than in an unreset RAM.
      for (int i = 0; i < NUM_SETS; i++) plru[i] <= '0;
    end else begin
      state        <= state_next;
      way_sel_q    <= way_sel_d;
      victim_q     <= victim_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      fill_req_q   <= fill_req_d;
      err_q        <= err_d;
      if (capture) begin
        set_q   <= bus.req_set;
        hit_q   <= bus.hit_vec;
`ifdef WAY_SEL_INVALID_FIRST_EN
        valid_q <= bus.valid_vec;
`endif
      end
      if (plru_we) plru[set_q] <= plru_touch(plru_cur, plru_way);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next   = state;
    way_sel_d    = way_sel_q;
    victim_d     = victim_q;
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    fill_req_d   = fill_req_q;
    err_d        = 1'b0;
    capture      = 1'b0;
    plru_we      = 1'b0;
    plru_way     = '0;
    case (state)
      IDLE: if (bus.req_valid) begin
        capture    = 1'b1;
        state_next = EVAL;
      end
      EVAL: if (|hit_q) begin
        // Multi-hit is flagged but still served as a hit on the lowest way.
        way_sel_d    = hit_low;
        resp_hit_d   = 1'b1;
        resp_valid_d = 1'b1;
        err_d        = multi_hit;
        plru_we      = 1'b1;
        plru_way     = hit_low;
        state_next   = RESP;
      end else begin
        victim_d   = victim_pick;
        fill_req_d = 1'b1;
        state_next = FILL;
      end
      FILL: if (bus.fill_done) begin
        fill_req_d   = 1'b0;
        way_sel_d    = victim_q;
        resp_hit_d   = 1'b0;
        resp_valid_d = 1'b1;
        plru_we      = 1'b1;
        plru_way     = victim_q;
        state_next   = RESP;
      end
      RESP: if (bus.resp_ready) begin
        resp_valid_d = 1'b0;
        way_sel_d    = '0;
        resp_hit_d   = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.way_sel      = way_sel_q;
  assign bus.victim_way   = victim_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_hit     = resp_hit_q;
  assign bus.fill_req     = fill_req_q;
  assign bus.err_multihit = err_q;

endmodule

// File: tb/tb_way_sel_ctrl.sv
// Directed, table-driven bench for way_sel_ctrl with hand-computed PLRU expectations.
// Extra vectors for WAY_SEL_INVALID_FIRST_EN are compiled in when that macro is defined.
module tb_way_sel_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  way_sel_ctrl_if #(.SET_IDX_W(6)) bus ();

  way_sel_ctrl #(.NUM_SETS(64), .SET_IDX_W(6)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] set;
    logic [3:0] hit;
    logic [3:0] valid;
    logic [3:0] exp_way;
    logic       exp_hit;
    logic       exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full lookup; request accepted at the first edge, result visible after the second.
  task automatic run_lookup(input vec_t v, input string tag);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_set   = v.set;
    bus.hit_vec   = v.hit;
`ifdef WAY_SEL_INVALID_FIRST_EN
    bus.valid_vec = v.valid;
`endif
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.hit_vec   = 4'b0000;
    check({tag, "_busy"}, 4'(bus.req_ready), 4'd0);
    check({tag, "_eval_quiet"}, {2'b00, bus.resp_valid, bus.fill_req}, 4'd0);
    @(negedge clk);
    if (v.exp_hit) begin
      check({tag, "_resp_valid"}, 4'(bus.resp_valid), 4'd1);
      check({tag, "_way_sel"}, bus.way_sel, v.exp_way);
      check({tag, "_resp_hit"}, 4'(bus.resp_hit), 4'd1);
      check({tag, "_err"}, 4'(bus.err_multihit), 4'(v.exp_err));
    end else begin
      check({tag, "_fill_req"}, 4'(bus.fill_req), 4'd1);
      check({tag, "_victim"}, bus.victim_way, v.exp_way);
      check({tag, "_no_resp"}, 4'(bus.resp_valid), 4'd0);
      repeat (2) @(negedge clk);
      check({tag, "_fill_hold"}, {bus.fill_req, bus.victim_way[2:0]}, {1'b1, v.exp_way[2:0]});
      bus.fill_done = 1'b1;
      @(negedge clk);
      bus.fill_done = 1'b0;
      check({tag, "_fill_drop"}, 4'(bus.fill_req), 4'd0);
      check({tag, "_resp_valid"}, 4'(bus.resp_valid), 4'd1);
      check({tag, "_way_sel"}, bus.way_sel, v.exp_way);
      check({tag, "_resp_hit"}, 4'(bus.resp_hit), 4'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "_err_clear"}, 4'(bus.err_multihit), 4'd0);
    check({tag, "_released"}, {bus.resp_valid, bus.req_ready, 2'b00}, 4'b0100);
    check({tag, "_way_clear"}, bus.way_sel, 4'd0);
  endtask

  initial begin
    // Cumulative PLRU history (b0,b1,b2) is tracked by hand in the comments.
    vecs[0]  = '{6'd5,  4'b0100, 4'hF, 4'b0100, 1'b1, 1'b0}; // set5 -> b0=0 b2=1
    vecs[1]  = '{6'd3,  4'b0000, 4'hF, 4'b0001, 1'b0, 1'b0}; // set3 000 -> way0
    vecs[2]  = '{6'd3,  4'b0000, 4'hF, 4'b0100, 1'b0, 1'b0}; // 1,1,0 -> way2
    vecs[3]  = '{6'd3,  4'b0000, 4'hF, 4'b0010, 1'b0, 1'b0}; // 0,1,1 -> way1
    vecs[4]  = '{6'd3,  4'b0000, 4'hF, 4'b1000, 1'b0, 1'b0}; // 1,0,1 -> way3
    vecs[5]  = '{6'd5,  4'b0000, 4'hF, 4'b0001, 1'b0, 1'b0}; // 0,0,1 -> way0
    vecs[6]  = '{6'd5,  4'b0000, 4'hF, 4'b1000, 1'b0, 1'b0}; // 1,1,1 -> way3
    vecs[7]  = '{6'd9,  4'b1010, 4'hF, 4'b0010, 1'b1, 1'b1}; // multi-hit -> way1
    vecs[8]  = '{6'd9,  4'b0000, 4'hF, 4'b0100, 1'b0, 1'b0}; // 1,0,0 -> way2
    vecs[9]  = '{6'd3,  4'b1111, 4'hF, 4'b0001, 1'b1, 1'b1}; // set3 000, hit way0
    vecs[10] = '{6'd3,  4'b0000, 4'hF, 4'b0100, 1'b0, 1'b0}; // 1,1,0 -> way2
    vecs[11] = '{6'd0,  4'b1000, 4'hF, 4'b1000, 1'b1, 1'b0}; // set0 -> b0=0 b2=0
    vecs[12] = '{6'd0,  4'b0000, 4'hF, 4'b0001, 1'b0, 1'b0}; // 0,0,0 -> way0
    vecs[13] = '{6'd63, 4'b0000, 4'hF, 4'b0001, 1'b0, 1'b0}; // untouched set

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_set    = '0;
    bus.hit_vec    = '0;
    bus.resp_ready = 1'b0;
    bus.fill_done  = 1'b0;
`ifdef WAY_SEL_INVALID_FIRST_EN
    bus.valid_vec  = 4'hF;
`endif
    repeat (2) @(negedge clk);
    check("rst_req_ready", 4'(bus.req_ready), 4'd1);
    check("rst_flags", {bus.resp_valid, bus.resp_hit, bus.fill_req, bus.err_multihit}, 4'd0);
    check("rst_way_sel", bus.way_sel, 4'd0);
    check("rst_victim", bus.victim_way, 4'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_lookup(vecs[i], $sformatf("v%0d", i));

    // fill_done in IDLE must be ignored.
    @(negedge clk);
    bus.fill_done = 1'b1;
    @(negedge clk);
    bus.fill_done = 1'b0;
    check("stray_done_idle", {bus.req_ready, bus.resp_valid, bus.fill_req, 1'b0}, 4'b1000);

    // Back-pressure: hold resp_ready low for 5 cycles in RESP.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_set   = 6'd10;
    bus.hit_vec   = 4'b0010;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.hit_vec   = 4'b0000;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_flags", c), {bus.resp_valid, bus.resp_hit, bus.req_ready, 1'b0}, 4'b1100);
      check($sformatf("hold%0d_way", c), bus.way_sel, 4'b0010);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("hold_release", {bus.resp_valid, bus.req_ready, 2'b00}, 4'b0100);

    // Reset in FILL: set3 PLRU is 0,1,1 here, so the victim is way1 before reset, way0 after.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_set   = 6'd3;
    bus.hit_vec   = 4'b0000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_fill", {bus.fill_req, 3'b000}, 4'b1000);
    check("pre_rst_victim", bus.victim_way, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("rst_fill_drop", {bus.fill_req, bus.resp_valid, bus.req_ready, 1'b0}, 4'b0010);
    @(negedge clk);
    rst_n = 1'b1;
    run_lookup('{6'd3, 4'b0000, 4'hF, 4'b0001, 1'b0, 1'b0}, "post_rst");

`ifdef WAY_SEL_INVALID_FIRST_EN
    run_lookup('{6'd20, 4'b0000, 4'b1011, 4'b0100, 1'b0, 1'b0}, "inval_first");
    run_lookup('{6'd20, 4'b0000, 4'hF,    4'b0001, 1'b0, 1'b0}, "inval_plru");
    run_lookup('{6'd3,  4'b0000, 4'b0111, 4'b1000, 1'b0, 1'b0}, "inval_way3");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
